alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execution unit on the consuming end of the 4-bit ALU operation code produced by the ALU controller. It accepts one operation (alu_op, operand A, operand B) per valid/ready handshake, computes the result, and returns it through a second valid/ready handshake. Shifts run iteratively, one bit per cycle, unless the fast-shift build option is enabled. Branch comparisons use the same unit and produce a taken flag for the PC logic.

## Interface
- XLEN, default 32: operand and result width. Only 32 is supported; the shift amount is b_i[4:0].
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream request valid.
- ready_o  out  1  unit can accept a request.
- alu_op_i  in  4  operation code: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, A BEQ, B BNE, C BLT, D BGE, E BLTU, F BGEU.
- a_i  in  XLEN  operand A (rs1).
- b_i  in  XLEN  operand B (rs2 or immediate).
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  XLEN  registered result.
- branch_taken_o  out  1  registered compare outcome. It is 0 for ops 0–9.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **ready_o** is 1 only in IDLE with rst_ni high. It is forced to 0 while rst_ni is low.
- **Accept:** a request is accepted when valid_i & ready_o. Operands and op are captured into internal registers. Inputs are ignored in all other cycles.
- **From IDLE on accept:**
  - For ops 0–4 and 8–F, the result is computed combinationally from the captured inputs, registered, and the FSM goes to DONE.
  - For ops 5–7, the FSM loads the shift register with a_i and the counter with b_i[4:0], then goes to SHIFT. If the counter is 0, it goes straight to DONE with result = a_i.
- **SHIFT:** each cycle shifts 1 bit (SLL: left, zero-fill; SRL: right, zero-fill; SRA: right, sign-fill from bit 31) and decrements the counter. When the counter goes from 1 to 0, the FSM goes to DONE with the final value in result_o.
- **DONE:** valid_o = 1. result_o and branch_taken_o are held stable until ready_i = 1, then the FSM returns to IDLE.
- **Arithmetic rules:**
  - ADD/SUB wrap modulo 2^32; no carry or overflow output.
  - SLT/BLT/BGE use signed compare; SLTU/BLTU/BGEU use unsigned compare.
  - SLT/SLTU write {31'b0, cmp}.
  - Branch ops write result_o = {31'b0, taken} and branch_taken_o = taken.
  - BEQ/BNE compare all 32 bits.
- **Reset mid-operation:** when rst_ni is asserted in any state, the FSM returns to IDLE immediately and any in-flight operation is discarded with no result emitted.

## Timing
- **Reset values:** state IDLE, valid_o 0, result_o 0, branch_taken_o 0, ready_o 0 while in reset and 1 after release.
- **Non-shift ops:** accept in cycle N; valid_o = 1 in cycle N+1. With ready_i = 1 in N+1, ready_o = 1 in N+2. Maximum throughput is one op per 2 cycles.
- **Shift ops (iterative):** accept in cycle N with shamt s; valid_o = 1 in cycle N+1+s (s = 0 gives N+1). Worst case is s = 31, giving valid_o in N+32.
- **Backpressure:** with ready_i = 0, DONE holds indefinitely. valid_o never drops without a handshake.
- **Simultaneous events:** valid_i is ignored while ready_o = 0, so no request is lost or queued. Upstream must hold valid_i until it sees ready_o.
- **No combinational paths:** none from valid_i/ready_i to valid_o/ready_o; ready_o depends only on state and rst_ni.

## Configuration
- **FAST_SHIFT_EN defined:** SLL/SRL/SRA use a single-cycle barrel shifter, take the same path as other ops (latency 1), and the SHIFT state is not used.
- **FAST_SHIFT_EN undefined:** shifts use the iterative SHIFT state with latency s+1 as above. This is the default build.

## Test plan
- **Reset:** apply reset, then release -> ready_o = 1, valid_o = 0, result_o = 0.
- **ADD and SUB:**
  - op 0, a = 0xFFFFFFFF, b = 0x00000002 -> result_o = 0x00000001 one cycle after accept.
  - op 1, a = 0, b = 1 -> result_o = 0xFFFFFFFF.
- **SRA (iterative):** op 7, a = 0x80000000, b = 0x00000004 -> result_o = 0xF8000000 with valid_o 5 cycles after accept. With FAST_SHIFT_EN defined, the same result arrives after 1 cycle.
- **Shift by zero and by 31:**
  - SLL with b = 0 -> result_o = a_i after 1 cycle.
  - SLL with a = 1, b = 31 -> result_o = 0x80000000 after 32 cycles.
- **Branch compares:**
  - BLT, a = 0xFFFFFFFF, b = 1 -> branch_taken_o = 1, result_o = 1.
  - BLTU with the same operands -> branch_taken_o = 0, result_o = 0.
- **Backpressure and reset:**
  - Hold ready_i = 0 for 5 cycles in DONE -> result_o stable, ready_o = 0, new valid_i ignored.
  - Assert rst_ni low mid-SHIFT -> valid_o never rises; after release, ready_o = 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ALU execution unit: one op per valid/ready handshake, registered result and branch flag.
// Build option FAST_SHIFT_EN: single-cycle barrel shifts instead of the iterative SHIFT state.
module alu_exec_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      alu_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            branch_taken_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]      state;
    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic            alu_taken;
    logic            lt_s;
    logic            lt_u;
    logic            eq;

    assign ready_o = rst_ni && (state == ST_IDLE);
    assign valid_o = (state == ST_DONE);
    assign accept  = valid_i && ready_o;

    always_comb begin
        alu_res   = '0;
        alu_taken = 1'b0;
        lt_s      = $signed(a_i) < $signed(b_i);
        lt_u      = a_i < b_i;
        eq        = (a_i == b_i);
        case (alu_op_i)
            4'h0: alu_res = a_i + b_i;
            4'h1: alu_res = a_i - b_i;
            4'h2: alu_res = a_i ^ b_i;
            4'h3: alu_res = a_i | b_i;
            4'h4: alu_res = a_i & b_i;
`ifdef FAST_SHIFT_EN
            4'h5: alu_res = a_i << b_i[4:0];
            4'h6: alu_res = a_i >> b_i[4:0];
            4'h7: alu_res = $unsigned($signed(a_i) >>> b_i[4:0]);
`else
            // Zero-amount shifts finish on accept with the unshifted operand.
            4'h5, 4'h6, 4'h7: alu_res = a_i;
`endif
            4'h8: alu_res = {{(XLEN-1){1'b0}}, lt_s};
            4'h9: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            4'hA: alu_taken = eq;
            4'hB: alu_taken = !eq;
            4'hC: alu_taken = lt_s;
            4'hD: alu_taken = !lt_s;
            4'hE: alu_taken = lt_u;
            default: alu_taken = !lt_u;
        endcase
        if (alu_op_i >= 4'hA) begin
            alu_res = {{(XLEN-1){1'b0}}, alu_taken};
        end
    end

`ifndef FAST_SHIFT_EN
    logic [3:0]      op_q;
    logic [XLEN-1:0] sh_q;
    logic [XLEN-1:0] sh_next;
    logic [4:0]      cnt_q;
    logic            is_shift;

    assign is_shift = (alu_op_i == 4'h5) || (alu_op_i == 4'h6) || (alu_op_i == 4'h7);

    always_comb begin
        case (op_q)
            4'h5:    sh_next = {sh_q[XLEN-2:0], 1'b0};
            4'h6:    sh_next = {1'b0, sh_q[XLEN-1:1]};
            default: sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        endcase
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_IDLE;
            result_o       <= '0;
            branch_taken_o <= 1'b0;
`ifndef FAST_SHIFT_EN
            op_q           <= '0;
            sh_q           <= '0;
            cnt_q          <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        result_o       <= alu_res;
                        branch_taken_o <= alu_taken;
                        state          <= ST_DONE;
`ifndef FAST_SHIFT_EN
                        if (is_shift) begin
                            op_q  <= alu_op_i;
                            sh_q  <= a_i;
                            cnt_q <= b_i[4:0];
                            if (b_i[4:0] != 5'd0) begin
                                state <= ST_SHIFT;
                            end
                        end
`endif
                    end
                end
                ST_SHIFT: begin
`ifndef FAST_SHIFT_EN
                    sh_q  <= sh_next;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_o <= sh_next;
                        state    <= ST_DONE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: arithmetic, shifts, branches, backpressure, reset.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  alu_op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        branch_taken_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .alu_op_i       (alu_op),
        .a_i            (a_in),
        .b_i            (b_in),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .result_o       (result_o),
        .branch_taken_o (branch_taken_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {31'b0, ready_o}, 32'd1);
        valid_i = 1'b1;
        alu_op  = op;
        a_in    = a;
        b_in    = b;
        @(posedge clk);
        #1;
        // Scramble inputs after accept so the unit must use its captured copies.
        valid_i = 1'b0;
        alu_op  = 4'($urandom);
        a_in    = $urandom;
        b_in    = $urandom;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic retire();
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check("ready_after", {31'b0, ready_o}, 32'd1);
        check("valid_after", {31'b0, valid_o}, 32'd0);
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input logic exp_taken);
        int lat;
        int exp_lat;
`ifdef FAST_SHIFT_EN
        exp_lat = 1;
`else
        exp_lat = (op >= 4'h5 && op <= 4'h7) ? 1 + int'(b[4:0]) : 1;
`endif
        send(op, a, b);
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_tkn"}, {31'b0, branch_taken_o}, {31'b0, exp_taken});
        retire();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        alu_op  = '0;
        a_in    = '0;
        b_in    = '0;
        #12;
        check("rst_ready", {31'b0, ready_o}, 32'd0);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_taken", {31'b0, branch_taken_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", {31'b0, ready_o}, 32'd1);
        check("rel_valid", {31'b0, valid_o}, 32'd0);

        run_vec("add",   4'h0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0);
        run_vec("sub",   4'h1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        run_vec("xor",   4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
        run_vec("or",    4'h3, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0);
        run_vec("and",   4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        run_vec("sra4",  4'h7, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0);
        run_vec("sll0",  4'h5, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0);
        run_vec("sll31", 4'h5, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0);
        run_vec("srl3",  4'h6, 32'h80000000, 32'h00000003, 32'h10000000, 1'b0);
        run_vec("sra_p", 4'h7, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0);
        run_vec("srl_hi",4'h6, 32'h80000000, 32'h00000021, 32'h40000000, 1'b0);
        run_vec("slt",   4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        run_vec("sltu",  4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        run_vec("blt",   4'hC, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1);
        run_vec("bltu",  4'hE, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        run_vec("beq_t", 4'hA, 32'h80000000, 32'h80000000, 32'h00000001, 1'b1);
        run_vec("beq_n", 4'hA, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
        run_vec("bne",   4'hB, 32'h80000000, 32'h00000000, 32'h00000001, 1'b1);
        run_vec("bge",   4'hD, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b1);
        run_vec("bge_eq",4'hD, 32'h00000005, 32'h00000005, 32'h00000001, 1'b1);
        run_vec("bgeu",  4'hF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0);

        // Backpressure: DONE holds while new requests are presented and must be ignored.
        send(4'h0, 32'd3, 32'd4);
        wait_result(lat);
        check("bp_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            alu_op  = 4'h1;
            a_in    = 32'd100;
            b_in    = 32'd1;
            @(posedge clk);
            #1;
            check("bp_result", result_o, 32'd7);
            check("bp_valid", {31'b0, valid_o}, 32'd1);
            check("bp_ready", {31'b0, ready_o}, 32'd0);
        end
        valid_i = 1'b0;
        retire();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_noqueue", {31'b0, valid_o}, 32'd0);
        end

        // Reset in the middle of a long shift discards the operation.
        send(4'h5, 32'd1, 32'd20);
        repeat (3) @(posedge clk);
        #1;
`ifndef FAST_SHIFT_EN
        check("mid_valid", {31'b0, valid_o}, 32'd0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, ready_o}, 32'd0);
        check("mid_rst_valid", {31'b0, valid_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen++;
        end
        check("rst_no_result", 32'(seen), 32'd0);
        check("rst_ready_after", {31'b0, ready_o}, 32'd1);
        check("rst_result_clr", result_o, 32'd0);

        run_vec("post_rst", 4'h0, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
